// File: rtl/sobel_pkg.sv
// Shared types and constants for the sobel frame sequencer.
package sobel_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StExec,
        StWrite,
        StDone
    } state_e;

    localparam logic [2:0] MODE_O1 = 3'd0;
    localparam logic [2:0] MODE_O2 = 3'd1;
    localparam logic [2:0] MODE_O3 = 3'd2;
    localparam logic [2:0] MODE_O4 = 3'd3;
    localparam logic [2:0] MODE_O5 = 3'd4;

    typedef logic [7:0]        pixel_t;
    typedef logic signed [8:0] result_t;

    // Inputs are clipped to +/-255 upstream, so negation cannot overflow.
    function automatic result_t abs_res(result_t v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/sobel_ctrl_if.sv
// Host, input-RAM, sobel-core and output-RAM signals of sobel_ctrl.
// master = controller view, slave = surrounding environment view.
interface sobel_ctrl_if #(parameter int AW = 12);
    import sobel_pkg::*;

    logic            start;
    logic [2:0]      mode;
    logic            busy;
    logic            done;
    logic            ren;
    logic [AW-1:0]   raddr;
    pixel_t          rdata;
    logic            sob_en;
    pixel_t          sob_i0, sob_i1, sob_i2, sob_i3, sob_i4, sob_i5, sob_i6, sob_i7, sob_i8;
    result_t         sob_o1, sob_o2, sob_o3, sob_o4, sob_o5;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [8:0]      wdata;

    modport master (
        input  start, mode, rdata, sob_o1, sob_o2, sob_o3, sob_o4, sob_o5,
        output busy, done, ren, raddr, sob_en, wen, waddr, wdata,
        output sob_i0, sob_i1, sob_i2, sob_i3, sob_i4, sob_i5, sob_i6, sob_i7, sob_i8
    );

    modport slave (
        output start, mode, rdata, sob_o1, sob_o2, sob_o3, sob_o4, sob_o5,
        input  busy, done, ren, raddr, sob_en, wen, waddr, wdata,
        input  sob_i0, sob_i1, sob_i2, sob_i3, sob_i4, sob_i5, sob_i6, sob_i7, sob_i8
    );

endinterface

// File: rtl/sobel_win_addr.sv
// Window tap locator: maps centre (x, y) and tap index k (row-major 3x3) to an input-RAM
// address and an in-bounds flag.
module sobel_win_addr #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int AW    = 12
) (
    input  logic [AW-1:0] i_x,
    input  logic [AW-1:0] i_y,
    input  logic [3:0]    i_k,
    output logic          o_in_bounds,
    output logic [AW-1:0] o_addr
);

    localparam logic signed [AW+1:0] ColMax = (AW+2)'(IMG_W - 1);
    localparam logic signed [AW+1:0] RowMax = (AW+2)'(IMG_H - 1);
    localparam logic [AW-1:0]        Width  = AW'(IMG_W);

    logic signed [AW+1:0] w_dx, w_dy, w_col, w_row;

    always_comb begin
        w_dx = (AW+2)'(1);
        w_dy = (AW+2)'(1);
        case (i_k)
            4'd0, 4'd3, 4'd6: w_dx = '1;
            4'd1, 4'd4, 4'd7: w_dx = '0;
            default:          w_dx = (AW+2)'(1);
        endcase
        case (i_k)
            4'd0, 4'd1, 4'd2: w_dy = '1;
            4'd3, 4'd4, 4'd5: w_dy = '0;
            default:          w_dy = (AW+2)'(1);
        endcase
    end

    // Two guard bits let x-1 / y-1 go negative without wrapping.
    assign w_col = $signed({2'b00, i_x}) + w_dx;
    assign w_row = $signed({2'b00, i_y}) + w_dy;

    assign o_in_bounds = !w_col[AW+1] && (w_col <= ColMax) && !w_row[AW+1] && (w_row <= RowMax);
    assign o_addr      = w_row[AW-1:0] * Width + w_col[AW-1:0];

endmodule

// File: rtl/sobel_ctrl.sv
// Frame sequencer for the sobel core: scans the image, builds zero-padded 3x3 windows and writes
// the mode-selected result. Define SOBEL_CTRL_ABS_EN to write magnitudes instead of signed values.
module sobel_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int AW    = 12
) (
    input logic          clk,
    input logic          rst,
    sobel_ctrl_if.master bus
);

    localparam logic [AW-1:0] XMax  = AW'(IMG_W - 1);
    localparam logic [AW-1:0] YMax  = AW'(IMG_H - 1);
    localparam logic [AW-1:0] Width = AW'(IMG_W);

    state_e        r_state, w_state_nxt;
    logic [3:0]    r_k, r_dk;
    logic          r_dv, r_dinb;
    logic [AW-1:0] r_x, r_y;
    logic [2:0]    r_mode;
    pixel_t        r_tap [9];

    logic          w_inb, w_last;
    logic [AW-1:0] w_addr;
    result_t       w_sel;
    logic [8:0]    w_wval;

    sobel_win_addr #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) u_win_addr (
        .i_x        (r_x),
        .i_y        (r_y),
        .i_k        (r_k),
        .o_in_bounds(w_inb),
        .o_addr     (w_addr)
    );

    assign w_last = (r_x == XMax) && (r_y == YMax);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (bus.start) w_state_nxt = StFetch;
            StFetch: if (r_k == 4'd8) w_state_nxt = StDrain;
            StDrain: w_state_nxt = StExec;
            StExec:  w_state_nxt = StWrite;
            StWrite: w_state_nxt = w_last ? StDone : StFetch;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_sel = bus.sob_o1;
        case (r_mode)
            MODE_O1: w_sel = bus.sob_o1;
            MODE_O2: w_sel = bus.sob_o2;
            MODE_O3: w_sel = bus.sob_o3;
            MODE_O4: w_sel = bus.sob_o4;
            MODE_O5: w_sel = bus.sob_o5;
            default: w_sel = bus.sob_o1;
        endcase
    end

`ifdef SOBEL_CTRL_ABS_EN
    result_t w_abs;
    assign w_abs  = abs_res(w_sel);
    assign w_wval = {1'b0, w_abs[7:0]};
`else
    assign w_wval = w_sel;
`endif

    assign bus.busy   = (r_state == StFetch) || (r_state == StDrain) ||
                        (r_state == StExec)  || (r_state == StWrite);
    assign bus.done   = (r_state == StDone);
    assign bus.ren    = (r_state == StFetch) && w_inb;
    assign bus.raddr  = bus.ren ? w_addr : '0;
    assign bus.sob_en = (r_state == StExec);
    assign bus.wen    = (r_state == StWrite);
    assign bus.waddr  = bus.wen ? (r_y * Width + r_x) : '0;
    assign bus.wdata  = bus.wen ? w_wval : '0;

    assign bus.sob_i0 = r_tap[0];
    assign bus.sob_i1 = r_tap[1];
    assign bus.sob_i2 = r_tap[2];
    assign bus.sob_i3 = r_tap[3];
    assign bus.sob_i4 = r_tap[4];
    assign bus.sob_i5 = r_tap[5];
    assign bus.sob_i6 = r_tap[6];
    assign bus.sob_i7 = r_tap[7];
    assign bus.sob_i8 = r_tap[8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read data lags the address by one cycle, so tap k-1 lands while tap k is addressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k    <= '0;
            r_dk   <= '0;
            r_dv   <= 1'b0;
            r_dinb <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_mode <= '0;
            for (int i = 0; i < 9; i++) r_tap[i] <= '0;
        end else begin
            r_dv   <= (r_state == StFetch);
            r_dinb <= w_inb;
            r_dk   <= r_k;
            if (r_dv) r_tap[r_dk] <= r_dinb ? bus.rdata : '0;
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        r_x    <= '0;
                        r_y    <= '0;
                        r_k    <= '0;
                    end
                end
                StFetch: r_k <= (r_k == 4'd8) ? 4'd0 : r_k + 4'd1;
                StWrite: begin
                    if (r_x == XMax) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_ctrl.sv
// Bench for sobel_ctrl: a 3x3 and a 4x2 instance, each with behavioural RAMs and sobel core,
// checked against a zero-padded software Sobel model of the whole frame.
module tb_sobel_ctrl;
    import sobel_pkg::*;

    localparam int AW = 12;

    typedef struct {
        int         img;
        logic [2:0] mode;
        int         addr;
        int         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cur_img [16];
    int   mem_a [16];
    int   mem_b [16];
    int   out_a [16];
    int   out_b [16];

    sobel_ctrl_if #(.AW(AW)) ifa ();
    sobel_ctrl_if #(.AW(AW)) ifb ();

    sobel_ctrl #(.IMG_W(3), .IMG_H(3), .AW(AW)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    sobel_ctrl #(.IMG_W(4), .IMG_H(2), .AW(AW)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    function automatic int clip(int v);
        return (v > 255) ? 255 : ((v < -255) ? -255 : v);
    endfunction

    // Sobel core outputs: o1=Gx, o2=Gy, o3=diag, o4=|Gx|+|Gy|, o5=anti-diag, all clipped.
    function automatic int sob_fn(input int t[9], input int n);
        int gx, gy;
        gx = (t[2] + 2*t[5] + t[8]) - (t[0] + 2*t[3] + t[6]);
        gy = (t[6] + 2*t[7] + t[8]) - (t[0] + 2*t[1] + t[2]);
        case (n)
            1:       return clip(gy);
            2:       return clip((t[0] + 2*t[1] + t[3]) - (t[5] + 2*t[7] + t[8]));
            3:       return clip((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy));
            4:       return clip((t[1] + 2*t[2] + t[5]) - (t[3] + 2*t[6] + t[7]));
            default: return clip(gx);
        endcase
    endfunction

    function automatic int core_a(int n);
        int t[9];
        t = '{int'(ifa.sob_i0), int'(ifa.sob_i1), int'(ifa.sob_i2), int'(ifa.sob_i3),
              int'(ifa.sob_i4), int'(ifa.sob_i5), int'(ifa.sob_i6), int'(ifa.sob_i7),
              int'(ifa.sob_i8)};
        return sob_fn(t, n);
    endfunction

    function automatic int core_b(int n);
        int t[9];
        t = '{int'(ifb.sob_i0), int'(ifb.sob_i1), int'(ifb.sob_i2), int'(ifb.sob_i3),
              int'(ifb.sob_i4), int'(ifb.sob_i5), int'(ifb.sob_i6), int'(ifb.sob_i7),
              int'(ifb.sob_i8)};
        return sob_fn(t, n);
    endfunction

    // Synchronous-read RAMs and registered sobel cores around each instance.
    always @(posedge clk) begin
        if (ifa.ren) ifa.rdata <= pixel_t'(mem_a[ifa.raddr[3:0]]);
        if (ifb.ren) ifb.rdata <= pixel_t'(mem_b[ifb.raddr[3:0]]);
        if (ifa.sob_en) begin
            ifa.sob_o1 <= result_t'(core_a(0));
            ifa.sob_o2 <= result_t'(core_a(1));
            ifa.sob_o3 <= result_t'(core_a(2));
            ifa.sob_o4 <= result_t'(core_a(3));
            ifa.sob_o5 <= result_t'(core_a(4));
        end
        if (ifb.sob_en) begin
            ifb.sob_o1 <= result_t'(core_b(0));
            ifb.sob_o2 <= result_t'(core_b(1));
            ifb.sob_o3 <= result_t'(core_b(2));
            ifb.sob_o4 <= result_t'(core_b(3));
            ifb.sob_o5 <= result_t'(core_b(4));
        end
    end

    function automatic int ref_raw(int w, int h, int x, int y, int m);
        int t[9];
        int c, r;
        for (int k = 0; k < 9; k++) begin
            c = x + (k % 3) - 1;
            r = y + (k / 3) - 1;
            t[k] = (c >= 0 && c < w && r >= 0 && r < h) ? cur_img[r*w + c] : 0;
        end
        return sob_fn(t, (m > 4) ? 0 : m);
    endfunction

    function automatic logic [8:0] to_w(int v);
`ifdef SOBEL_CTRL_ABS_EN
        return {1'b0, 8'((v < 0) ? -v : v)};
`else
        return 9'(v);
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int outs_a();
        return int'(ifa.busy | ifa.done | ifa.ren | ifa.sob_en | ifa.wen | (|ifa.raddr) |
                    (|ifa.waddr) | (|ifa.wdata) | (|ifa.sob_i0) | (|ifa.sob_i1) |
                    (|ifa.sob_i2) | (|ifa.sob_i3) | (|ifa.sob_i4) | (|ifa.sob_i5) |
                    (|ifa.sob_i6) | (|ifa.sob_i7) | (|ifa.sob_i8));
    endfunction

    task automatic set_img(input int id);
        cur_img = '{default: 0};
        if (id == 0) begin
            for (int i = 0; i < 9; i++) cur_img[i] = 10;
        end else begin
            cur_img[1] = 255;
            cur_img[2] = 255;
            cur_img[5] = 255;
        end
    endtask

    // Called at a negedge; returns at a negedge. lat = done cycle, -2 if reset, -1 on timeout.
    task automatic frame_a(input logic [2:0] m, input bit disturb, input int rst_at,
                           output int lat, output int nw, output int viol,
                           output logic [8:0] renbits);
        int n;
        out_a = '{default: -1};
        ifa.mode  = m;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        n = 1; nw = 0; lat = -1; viol = 0; renbits = '0;
        while (n <= 400) begin
            if (int'(ifa.ren) + int'(ifa.wen) + int'(ifa.sob_en) > 1) viol++;
            if (n <= 9) renbits[n-1] = ifa.ren;
            if (ifa.wen) begin
                if (n != 12*(nw + 1) || int'(ifa.waddr) != nw) viol++;
                out_a[ifa.waddr[3:0]] = int'(ifa.wdata);
                nw++;
            end
            if (ifa.done) begin
                if (ifa.busy) viol++;
                lat = n;
                break;
            end
            if (!ifa.busy) viol++;
            if (disturb && n == 30) begin
                ifa.start = 1'b1;
                ifa.mode  = m ^ 3'b011;
            end
            if (disturb && n == 31) ifa.start = 1'b0;
            if (n == rst_at) begin
                chk("exec_before_rst", int'(ifa.sob_en), 1);
                rst = 1'b0;
                #1;
                chk("rst_outputs_zero", outs_a(), 0);
                repeat (2) begin
                    @(negedge clk);
                    if (ifa.wen || ifa.busy) viol++;
                end
                rst = 1'b1;
                @(negedge clk);
                if (ifa.wen || ifa.busy) viol++;
                lat = -2;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (lat >= 0) begin
            @(negedge clk);
            if (ifa.done || ifa.busy || ifa.wen) viol++;
        end
    endtask

    task automatic frame_b(input logic [2:0] m, output int lat, output int viol);
        int n, nw;
        out_b = '{default: -1};
        ifb.mode  = m;
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        n = 1; nw = 0; lat = -1; viol = 0;
        while (n <= 300) begin
            if (int'(ifb.ren) + int'(ifb.wen) + int'(ifb.sob_en) > 1) viol++;
            if (ifb.wen) begin
                if (n != 12*(nw + 1) || int'(ifb.waddr) != nw) viol++;
                out_b[ifb.waddr[3:0]] = int'(ifb.wdata);
                nw++;
            end
            if (ifb.done) begin
                if (ifb.busy) viol++;
                lat = n;
                break;
            end
            if (!ifb.busy) viol++;
            @(negedge clk);
            n++;
        end
        if (nw != 8) viol++;
        @(negedge clk);
    endtask

    task automatic cmp_a(input string tag, input int m);
        for (int p = 0; p < 9; p++)
            chk($sformatf("%s_px%0d", tag, p), out_a[p], int'(to_w(ref_raw(3, 3, p % 3, p / 3, m))));
    endtask

    initial begin
        vec_t       vecs [8];
        int         lat, nw, viol;
        logic [8:0] renbits;
        logic [2:0] m;

        vecs[0] = '{img: 0, mode: 3'd0, addr: 0, exp: 30};
        vecs[1] = '{img: 0, mode: 3'd0, addr: 4, exp: 0};
        vecs[2] = '{img: 0, mode: 3'd2, addr: 0, exp: -40};
        vecs[3] = '{img: 0, mode: 3'd2, addr: 4, exp: 0};
        vecs[4] = '{img: 1, mode: 3'd3, addr: 4, exp: 255};
        vecs[5] = '{img: 0, mode: 3'd7, addr: 0, exp: 30};
        vecs[6] = '{img: 0, mode: 3'd1, addr: 0, exp: 30};
        vecs[7] = '{img: 0, mode: 3'd4, addr: 2, exp: -40};

        ifa.start = 1'b0; ifa.mode = '0;
        ifb.start = 1'b0; ifb.mode = '0;
        #1;
        chk("reset_outputs", outs_a(), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(ifa.busy), 0);

        for (int i = 0; i < 8; i++) begin
            set_img(vecs[i].img);
            mem_a = cur_img;
            frame_a(vecs[i].mode, 1'b0, -1, lat, nw, viol, renbits);
            chk($sformatf("v%0d_result", i), out_a[vecs[i].addr], int'(to_w(vecs[i].exp)));
            chk($sformatf("v%0d_done_cycle", i), lat, 109);
            chk($sformatf("v%0d_wen_count", i), nw, 9);
            chk($sformatf("v%0d_protocol", i), viol, 0);
            chk($sformatf("v%0d_corner_ren", i), int'(renbits), 'b110110000);
            cmp_a($sformatf("v%0d", i), int'(vecs[i].mode));
        end

        // Restart attempt and mode change while busy must not disturb the frame.
        set_img(0);
        mem_a = cur_img;
        frame_a(3'd2, 1'b1, -1, lat, nw, viol, renbits);
        chk("busy_restart_done_cycle", lat, 109);
        chk("busy_restart_wen_count", nw, 9);
        chk("busy_restart_protocol", viol, 0);
        cmp_a("busy_restart", 2);

        // Reset during pixel 5 EXEC, then a clean frame.
        frame_a(3'd0, 1'b0, 59, lat, nw, viol, renbits);
        chk("abort_marker", lat, -2);
        chk("abort_wen_count", nw, 4);
        chk("abort_protocol", viol, 0);
        set_img(1);
        mem_a = cur_img;
        frame_a(3'd1, 1'b0, -1, lat, nw, viol, renbits);
        chk("post_rst_done_cycle", lat, 109);
        chk("post_rst_protocol", viol, 0);
        cmp_a("post_rst", 1);

        // 4x2 instance with random images and modes.
        for (int f = 0; f < 4; f++) begin
            cur_img = '{default: 0};
            for (int i = 0; i < 8; i++) cur_img[i] = int'($urandom_range(0, 255));
            mem_b = cur_img;
            m = 3'($urandom_range(0, 7));
            frame_b(m, lat, viol);
            chk($sformatf("b%0d_done_cycle", f), lat, 97);
            chk($sformatf("b%0d_protocol", f), viol, 0);
            for (int p = 0; p < 8; p++)
                chk($sformatf("b%0d_px%0d", f, p), out_b[p],
                    int'(to_w(ref_raw(4, 2, p % 4, p / 4, int'(m)))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
